// File: rtl/angle_setpoint_ctrl.sv
// Angle setpoint controller.
// Three front-panel keys (increment, decrement, home) adjust one of NCH angle
// channels chosen by a one-hot switch bank. Each key is synchronised and
// debounced. Increment and decrement auto-repeat while they are held; home fires
// once per press. Increment and decrement saturate at MAX_ANGLE and at 0.
//
// Per-key hold FSM
//   state  | meaning
//   IDLE   | key released; a debounced press fires one event and arms the delay timer
//   HOLD   | key held; the timer counts down REPEAT_DLY cycles before repeating
//   REPEAT | key still held; one event each time the timer expires (REPEAT_RATE)
module angle_setpoint_ctrl #(
    parameter int NCH         = 4,
    parameter int AW          = 8,
    parameter int MAX_ANGLE   = 180,
    parameter int STEP        = 1,
    parameter int RST_ANGLE   = 0,
    parameter int DEB_CYC     = 50000,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_inc_n,
    input  logic              key_dec_n,
    input  logic              key_zero_n,
    input  logic [NCH-1:0]    sel,
    output logic [NCH*AW-1:0] angle,
    output logic [NCH-1:0]    upd,
    output logic              sel_err
);

    localparam int NK = 3;
    localparam int KI = 0;
    localparam int KD = 1;
    localparam int KZ = 2;

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYC);

    localparam int TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DLY_LOAD  = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] RATE_LOAD = TW'(REPEAT_RATE - 1);

    localparam logic [AW:0] STEP_X = (AW+1)'(STEP);
    localparam logic [AW:0] MAX_X  = (AW+1)'(MAX_ANGLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    logic [NK-1:0] key_raw_n;
    logic [NK-1:0] pressed;
    logic [NK-1:0] evt;

    assign key_raw_n = {key_zero_n, key_dec_n, key_inc_n};

    for (genvar k = 0; k < NK; k++) begin : g_key
        localparam bit REP_EN = (k != KZ);

        logic          sync1_n;
        logic          sync2_n;
        logic          deb_n;
        logic [DW-1:0] deb_cnt;
        hold_state_t   state;
        hold_state_t   state_nxt;
        logic [TW-1:0] timer;
        logic [TW-1:0] timer_nxt;
        logic          evt_k;

        // two-stage synchroniser, parked at "released" in reset
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_n <= 1'b1;
                sync2_n <= 1'b1;
            end else begin
                sync1_n <= key_raw_n[k];
                sync2_n <= sync1_n;
            end
        end

        // debounce: accept the new level once it has disagreed for DEB_CYC+1 samples
        always_ff @(posedge clk) begin
            if (rst) begin
                deb_n   <= 1'b1;
                deb_cnt <= '0;
            end else if (sync2_n == deb_n) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TC) begin
                deb_n   <= sync2_n;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end

        // hold FSM state and repeat timer registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                state <= state_nxt;
                timer <= timer_nxt;
            end
        end

        // hold FSM next state and event generation
        always_comb begin
            state_nxt = state;
            timer_nxt = timer;
            evt_k     = 1'b0;
            case (state)
                IDLE: begin
                    if (!deb_n) begin
                        evt_k     = 1'b1;
                        state_nxt = HOLD;
                        timer_nxt = DLY_LOAD;
                    end
                end
                HOLD: begin
                    if (deb_n) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (REP_EN) begin
                        if (timer == '0) begin
                            evt_k     = 1'b1;
                            state_nxt = REPEAT;
                            timer_nxt = RATE_LOAD;
                        end else begin
                            timer_nxt = timer - TW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (deb_n) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (timer == '0) begin
                        evt_k     = 1'b1;
                        timer_nxt = RATE_LOAD;
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end

        assign pressed[k] = ~deb_n;
        assign evt[k]     = evt_k;
    end

    logic sel_onehot;
    logic multi_press;
    logic evt_ok;

    assign sel_onehot  = (sel != '0) && ((sel & (sel - NCH'(1))) == '0);
    // a chord of keys is ambiguous, so any event during one is discarded
    assign multi_press = (pressed[KI] & pressed[KD]) | (pressed[KI] & pressed[KZ]) |
                         (pressed[KD] & pressed[KZ]);
    assign evt_ok      = (|evt) && !multi_press && sel_onehot;

    logic [AW-1:0] ang_nxt [NCH];
    logic [NCH-1:0] upd_nxt;
    logic [AW:0]    cur;
    logic [AW:0]    cand;

    // saturating update of the selected channel, one bit wider to avoid wrap
    always_comb begin
        upd_nxt = '0;
        cur     = '0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            cur  = {1'b0, angle[i*AW +: AW]};
            cand = cur;
            if (evt_ok && sel[i]) begin
                if (evt[KZ]) begin
                    cand = '0;
                end else if (evt[KI]) begin
                    cand = ((cur >= MAX_X) || (MAX_X - cur < STEP_X)) ? MAX_X : cur + STEP_X;
                end else if (evt[KD]) begin
                    cand = (cur < STEP_X) ? '0 : cur - STEP_X;
                end
            end
            ang_nxt[i] = cand[AW-1:0];
            upd_nxt[i] = (cand != cur);
        end
    end

    // angle, change pulse and select-error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                angle[i*AW +: AW] <= AW'(RST_ANGLE);
            end
            upd     <= '0;
            sel_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                angle[i*AW +: AW] <= ang_nxt[i];
            end
            upd     <= upd_nxt;
            sel_err <= !sel_onehot;
        end
    end

endmodule
